matmul_ctrl: RTL and testbench

//  Sequencer that runs an N x N signed 8-bit matrix product C = A * B through one

---
 rtl/matmul_ctrl.sv | 147 ++++++++++++++
 tb/tb_matmul_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl.sv
// ============================================================================
//  Module   : matmul_ctrl
//  Brief    : Sequences an N x N signed 8-bit matrix product through a shared
//             multiplier, reading A/B from 1-cycle-latency RAMs and writing C.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_ctrl #(
   parameter int N    = 4,
   parameter int AW   = (N == 1) ? 1 : $clog2(N * N),
   parameter int ACCW = 16 + $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   a_addr,
   input  logic [7:0]      a_data,
   output logic [AW-1:0]   b_addr,
   input  logic [7:0]      b_data,
   output logic            c_we,
   output logic [AW-1:0]   c_addr,
   output logic [ACCW-1:0] c_data,
   output logic            mul_ready,
   output logic [7:0]      mul_data1,
   output logic [7:0]      mul_data2,
   input  logic [15:0]     mul_result,
   input  logic            mul_done
);

   localparam int IW = (N == 1) ? 1 : $clog2(N);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_ACC, S_WRITE, S_DONE
   } state_t;

   state_t                 r_state;
   logic [IW-1:0]          r_i, r_j, r_k;
   logic signed [ACCW-1:0] r_acc;

   logic signed [ACCW-1:0] w_sum;
   logic                   w_last_k, w_last_j, w_last_i;
   logic [IW-1:0]          w_k_inc, w_j_next, w_i_next;

   function automatic logic [AW-1:0] f_addr(input logic [IW-1:0] row,
                                            input logic [IW-1:0] col);
      f_addr = AW'(32'(row) * 32'(N) + 32'(col));
   endfunction

   assign w_sum    = r_acc + ACCW'($signed(mul_result));
   assign w_last_k = (r_k == IW'(N - 1));
   assign w_last_j = (r_j == IW'(N - 1));
   assign w_last_i = (r_i == IW'(N - 1));
   assign w_k_inc  = r_k + IW'(1);
   assign w_j_next = w_last_j ? '0 : r_j + IW'(1);
   assign w_i_next = w_last_j ? r_i + IW'(1) : r_i;

   // Outputs are registered on entry to the state that owns them, so each
   // strobe is high exactly during its named state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_acc     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         a_addr    <= '0;
         b_addr    <= '0;
         c_we      <= 1'b0;
         c_addr    <= '0;
         c_data    <= '0;
         mul_ready <= 1'b0;
         mul_data1 <= '0;
         mul_data2 <= '0;
      end else begin
         done      <= 1'b0;
         c_we      <= 1'b0;
         mul_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  r_state <= S_FETCH;
                  busy    <= 1'b1;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_k     <= '0;
                  r_acc   <= '0;
                  a_addr  <= '0;
                  b_addr  <= '0;
               end
            end
            S_FETCH: r_state <= S_LOAD;
            S_LOAD: begin
               mul_data1 <= a_data;
               mul_data2 <= b_data;
               mul_ready <= 1'b1;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               if (mul_done) r_state <= S_ACC;
            end
            S_ACC: begin
               r_acc <= w_sum;
               if (w_last_k) begin
                  c_we    <= 1'b1;
                  c_addr  <= f_addr(r_i, r_j);
                  c_data  <= w_sum;
                  r_state <= S_WRITE;
               end else begin
                  r_k     <= w_k_inc;
                  a_addr  <= f_addr(r_i, w_k_inc);
                  b_addr  <= f_addr(w_k_inc, r_j);
                  r_state <= S_FETCH;
               end
            end
            S_WRITE: begin
               r_acc <= '0;
               r_k   <= '0;
               r_j   <= w_j_next;
               r_i   <= w_i_next;
               if (w_last_i && w_last_j) begin
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  a_addr  <= f_addr(w_i_next, '0);
                  b_addr  <= f_addr('0, w_j_next);
                  r_state <= S_FETCH;
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_matmul_ctrl.sv
// ============================================================================
//  Module   : tb_matmul_ctrl
//  Brief    : Self-checking bench for matmul_ctrl with RAM and multiplier models
//             and a scoreboard of expected C writes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_ctrl;

   localparam int N    = 4;
   localparam int AW   = 4;
   localparam int ACCW = 18;
   localparam int RUN_CYC = 913;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            busy, done, c_we, mul_ready, mul_done;
   logic [AW-1:0]   a_addr, b_addr, c_addr;
   logic [7:0]      a_data, b_data, mul_data1, mul_data2;
   logic [ACCW-1:0] c_data;
   logic [15:0]     mul_result;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [ACCW-1:0] data;
   } exp_t;

   exp_t sbq[$];
   logic signed [7:0] mem_a [N*N];
   logic signed [7:0] mem_b [N*N];
   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   int prod_cnt = 0;
   int stall_at = -1;
   logic prev_ready = 1'b0;
   int mul_cnt = 0;

   matmul_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
      .c_we(c_we), .c_addr(c_addr), .c_data(c_data),
      .mul_ready(mul_ready), .mul_data1(mul_data1), .mul_data2(mul_data2),
      .mul_result(mul_result), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      a_data <= mem_a[a_addr];
      b_data <= mem_b[b_addr];
   end

   // Multiplier: accepts on ready, clears done, completes 9 cycles later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_cnt    <= 0;
         mul_done   <= 1'b0;
         mul_result <= '0;
      end else if (mul_ready) begin
         mul_cnt    <= (prod_cnt == stall_at) ? 29 : 9;
         mul_done   <= 1'b0;
         mul_result <= '0;
         prod_cnt   <= prod_cnt + 1;
      end else if (mul_cnt > 0) begin
         mul_cnt <= mul_cnt - 1;
         if (mul_cnt == 1) begin
            mul_done   <= 1'b1;
            mul_result <= 16'($signed(mul_data1) * $signed(mul_data2));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (c_we) begin
            exp_t e;
            we_cnt++;
            n_checks++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL c_write_unexpected: got addr=%0d data=%h, required no write",
                        c_addr, c_data);
            end else begin
               e = sbq.pop_front();
               if (c_addr !== e.addr || c_data !== e.data) begin
                  n_fail++;
                  $display("FAIL c_write: got addr=%0d data=%h, required addr=%0d data=%h",
                           c_addr, c_data, e.addr, e.data);
               end
            end
         end
         if (mul_ready) begin
            n_checks++;
            if (prev_ready) begin
               n_fail++;
               $display("FAIL mul_ready_width: got 2+ cycles high, required 1");
            end
         end
         prev_ready = mul_ready;
      end
   end

   task automatic push_expected();
      exp_t e;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int acc = 0;
            for (int k = 0; k < N; k++)
               acc += int'(mem_a[i*N+k]) * int'(mem_b[k*N+j]);
            e.addr = AW'(i*N + j);
            e.data = ACCW'(acc);
            sbq.push_back(e);
         end
   endtask

   task automatic fill_random();
      for (int n = 0; n < N*N; n++) begin
         mem_a[n] = 8'($urandom);
         mem_b[n] = 8'($urandom);
      end
   endtask

   // Pulses (or holds) start, then counts cycles after the accept edge until done
   task automatic do_run(input bit hold, output int cyc);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      cyc = 0;
      while (cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (done) break;
      end
   endtask

   task automatic check_run_end(input string name, input int cyc, input int exp_cyc);
      n_checks++;
      if (cyc !== exp_cyc) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, exp_cyc);
      end
      n_checks++;
      if (sbq.size() !== 0) begin
         n_fail++;
         $display("FAIL %s_writes: got %0d writes missing, required 0", name, sbq.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, c_we, mul_ready, a_addr, b_addr, c_addr, c_data, mul_data1, mul_data2} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b c_we=%b rdy=%b c_data=%h, required all 0",
                  busy, done, c_we, mul_ready, c_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_identity();
      int cyc;
      for (int n = 0; n < N*N; n++) begin
         mem_a[n] = (n / N == n % N) ? 8'sd1 : 8'sd0;
         mem_b[n] = 8'(n + 1);
      end
      push_expected();
      do_run(1'b0, cyc);
      check_run_end("identity", cyc, RUN_CYC);
      n_checks++;
      if (!(busy === 1'b1 && done === 1'b1)) begin
         n_fail++;
         $display("FAIL done_framing: got busy=%b done=%b, required 1 1", busy, done);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL after_done: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_const(input string name, input logic [7:0] va, input logic [7:0] vb);
      int cyc;
      for (int n = 0; n < N*N; n++) begin
         mem_a[n] = va;
         mem_b[n] = vb;
      end
      push_expected();
      do_run(1'b0, cyc);
      check_run_end(name, cyc, RUN_CYC);
   endtask

   task automatic test_random();
      int cyc;
      fill_random();
      push_expected();
      do_run(1'b0, cyc);
      check_run_end("random", cyc, RUN_CYC);
   endtask

   task automatic test_start_held();
      int cyc, we0;
      fill_random();
      push_expected();
      push_expected();
      do_run(1'b1, cyc);
      check_run_end_first: begin
         n_checks++;
         if (cyc !== RUN_CYC) begin
            n_fail++;
            $display("FAIL held_latency: got %0d cycles, required %0d", cyc, RUN_CYC);
         end
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_idle_gap: got busy=%b, required 0", busy);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL held_restart: got busy=%b, required 1", busy);
      end
      start = 1'b0;
      cyc = 1;
      repeat (5) begin
         @(negedge clk);
         cyc++;
      end
      start = 1'b1;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      while (cyc < 5000 && !done) begin
         @(negedge clk);
         cyc++;
      end
      check_run_end("held_second", cyc, RUN_CYC);
      we0 = we_cnt;
      repeat (100) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || we_cnt !== we0) begin
         n_fail++;
         $display("FAIL ignored_start: got busy=%b extra writes=%0d, required 0 0", busy, we_cnt - we0);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, base;
      fill_random();
      push_expected();
      base = we_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 5000 && we_cnt < base + 6) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, c_we, mul_ready, a_addr, b_addr, c_addr, c_data, mul_data1, mul_data2} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: got busy=%b rdy=%b a=%0d b=%0d c_data=%h, required all 0",
                  busy, mul_ready, a_addr, b_addr, c_data);
      end
      sbq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = we_cnt;
      push_expected();
      do_run(1'b0, cyc);
      check_run_end("after_reset", cyc, RUN_CYC);
      n_checks++;
      if (we_cnt - base !== 16) begin
         n_fail++;
         $display("FAIL after_reset_count: got %0d c_we pulses, required 16", we_cnt - base);
      end
   endtask

   task automatic test_stall();
      int cyc;
      fill_random();
      push_expected();
      stall_at = prod_cnt + int'($urandom_range(0, N*N*N - 1));
      do_run(1'b0, cyc);
      check_run_end("stall", cyc, RUN_CYC + 20);
      stall_at = -1;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_const("all_neg", 8'h80, 8'h80);
      test_const("pos_neg", 8'h7F, 8'h80);
      test_random();
      test_start_held();
      test_reset_mid();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
